// File: rtl/writeback_unit.sv
// writeback_unit
//   Writeback stage between the memory-access pipeline buffer and the
//   register file. It registers one bundle per accepted instruction and
//   selects either the ALU result or the extended/aligned load datum. It also
//   keeps a one-entry forwarding history and a retired-instruction counter.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   in_valid, stall      bundle qualifier and downstream hold
//   in_reg .. in_load_*  incoming writeback bundle
//   wb_en/wb_reg/wb_data register-file write port (one-cycle strobe)
//   fwd_*                previous completed write, for a second bypass cycle
//   retired_cnt          accepted valid instructions since reset (wraps)
module writeback_unit #(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [REG_AW-1:0] in_reg,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [OFF_W-1:0]  in_load_offset,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              accept;
  logic              zero_hit;
  logic [1:0]        size_eff;
  logic [OFF_W-1:0]  off_mask;
  logic [OFF_W-1:0]  off_eff;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] field_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] sel_data;

  assign accept   = in_valid & ~stall;
  assign zero_hit = (ZERO_REG != 0) && (in_reg == '0);

  // A 32-bit datapath has no dword loads; fold them onto word loads.
  always_comb begin
    size_eff = in_load_size;
    if (DATA_W == 32 && in_load_size == 2'd3) size_eff = 2'd2;
  end

  // Per-size alignment mask (misaligned offsets round down), field mask and
  // position of the field's sign bit.
  always_comb begin
    off_mask   = '1;
    field_mask = DATA_W'(8'hFF);
    case (size_eff)
      2'd0: begin
        off_mask   = '1;
        field_mask = DATA_W'(8'hFF);
      end
      2'd1: begin
        off_mask   = ~OFF_W'(1);
        field_mask = DATA_W'(16'hFFFF);
      end
      2'd2: begin
        off_mask   = ~OFF_W'(3);
        field_mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        off_mask   = ~OFF_W'(7);
        field_mask = '1;
      end
    endcase
  end

  assign off_eff = in_load_offset & off_mask;
  assign shifted = in_load_data >> {off_eff, 3'b000};

  always_comb begin
    sign_bit = shifted[7];
    case (size_eff)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
  end

  assign load_ext = (shifted & field_mask)
                  | (~field_mask & {DATA_W{sign_bit & ~in_load_unsigned}});
  assign sel_data = in_mem_to_reg ? load_ext : in_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en       <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      fwd_valid   <= 1'b0;
      fwd_reg     <= '0;
      fwd_data    <= '0;
      retired_cnt <= '0;
    end else begin
      // wb_en is a single-cycle strobe, so a held bundle is never written twice.
      wb_en <= accept & in_reg_write & ~zero_hit;
      if (accept) begin
        wb_reg      <= in_reg;
        wb_data     <= sel_data;
        retired_cnt <= retired_cnt + 1'b1;
      end
      // History follows completed writes only; suppressed x0 writes never reach it.
      if (wb_en) begin
        fwd_valid <= 1'b1;
        fwd_reg   <= wb_reg;
        fwd_data  <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit (DATA_W=64, CNT_W=4 so wrap is reachable).
module tb_writeback_unit;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          stall;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_result;
  logic [DW-1:0] in_load_data;
  logic          in_mem_to_reg;
  logic          in_reg_write;
  logic [1:0]    in_load_size;
  logic          in_load_unsigned;
  logic [OW-1:0] in_load_offset;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] retired_cnt;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .in_reg(in_reg), .in_result(in_result), .in_load_data(in_load_data),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_load_offset(in_load_offset),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired_cnt(retired_cnt)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] cnt_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write", wb_reg, wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_reg", 64'(wb_reg), 64'(e.r));
        chk("wb_data", wb_data, e.d);
        chk("wb_cnt", 64'(retired_cnt), 64'(e.c));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one valid bundle for one edge; model the accept and expected write.
  task automatic issue(input logic [AW-1:0] r, input logic [63:0] res, input logic [63:0] ld,
                       input logic m2r, input logic rw, input logic [1:0] sz,
                       input logic uns, input logic [OW-1:0] off, input logic [63:0] d_exp);
    in_valid = 1'b1; in_reg = r; in_result = res; in_load_data = ld;
    in_mem_to_reg = m2r; in_reg_write = rw; in_load_size = sz;
    in_load_unsigned = uns; in_load_offset = off;
    if (!stall && !rst) begin
      cnt_m++;
      if (rw && r != 0) sb.push_back('{r, d_exp, cnt_m});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_en"}, 64'(wb_en), 64'd0);
    chk({tag, "_wb_reg"}, 64'(wb_reg), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
    chk({tag, "_fwd_reg"}, 64'(fwd_reg), 64'd0);
    chk({tag, "_fwd_data"}, fwd_data, 64'd0);
    chk({tag, "_cnt"}, 64'(retired_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; in_valid = 1'b1; in_reg = 5'd9;
    in_result = 64'h99; in_load_data = '0; in_mem_to_reg = 1'b0;
    in_reg_write = 1'b1; in_load_size = 2'd0; in_load_unsigned = 1'b0;
    in_load_offset = '0; cnt_m = '0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0; in_valid = 1'b0;

    // ALU result then forwarding history
    issue(5'd7, 64'h1234, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h1234);
    chk("alu_cnt", 64'(retired_cnt), 64'd1);
    step();
    chk("alu_bubble", 64'(wb_en), 64'd0);
    chk("alu_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("alu_fwd_reg", 64'(fwd_reg), 64'd7);
    chk("alu_fwd_data", fwd_data, 64'h1234);

    // Load extension vectors
    issue(5'd8,  64'h0, 64'h0000_0000_0080_0000, 1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FF80);
    issue(5'd9,  64'h0, 64'h0000_0000_0080_0000, 1'b1, 1'b1, 2'd0, 1'b1, 3'd2, 64'h80);
    issue(5'd10, 64'h0, 64'h1122_3344_5566_8899, 1'b1, 1'b1, 2'd1, 1'b1, 3'd3, 64'h5566);
    issue(5'd11, 64'h0, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b1, 2'd2, 1'b0, 3'd5, 64'hFFFF_FFFF_8123_4567);
    issue(5'd12, 64'h0, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b1, 2'd3, 1'b0, 3'd6, 64'h8123_4567_89AB_CDEF);
    issue(5'd13, 64'h0, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b1, 2'd1, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_CDEF);
    issue(5'd14, 64'hDEAD_BEEF_0000_0001, 64'hFFFF, 1'b0, 1'b1, 2'd0, 1'b0, 3'd7, 64'hDEAD_BEEF_0000_0001);
    step();

    // Zero-register guard and non-writing instruction
    issue(5'd0, 64'h5555, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h0);
    chk("x0_wb_en", 64'(wb_en), 64'd0);
    chk("x0_cnt", 64'(retired_cnt), 64'd9);
    step();
    chk("x0_fwd_reg", 64'(fwd_reg), 64'd14);
    chk("x0_fwd_data", fwd_data, 64'hDEAD_BEEF_0000_0001);
    issue(5'd5, 64'h77, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0);
    chk("nowr_wb_en", 64'(wb_en), 64'd0);
    chk("nowr_cnt", 64'(retired_cnt), 64'd10);

    // Stall for three cycles, then release
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd3, 64'h33, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h33);
      chk("stall_wb_en", 64'(wb_en), 64'd0);
      chk("stall_cnt", 64'(retired_cnt), 64'd10);
    end
    stall = 1'b0;
    issue(5'd3, 64'h33, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h33);
    chk("release_wb_en", 64'(wb_en), 64'd1);
    step();
    chk("release_single", 64'(wb_en), 64'd0);

    // Reset overrides a valid bundle
    rst = 1'b1;
    issue(5'd4, 64'h44, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h44);
    chk_all_zero("rst_ovr");
    rst = 1'b0;
    cnt_m = '0;

    // Counter wrap: 17 accepted writes on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      issue(5'(i + 1), 64'(i) + 64'h100, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 64'(i) + 64'h100);
    end
    chk("wrap_cnt", 64'(retired_cnt), 64'd1);
    step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
